// File: rtl/debug_unit_ctrl.sv
// Host-side debug sequencer: loads instruction memory from UART bytes, runs or single-steps
// the pipeline, then streams the register file and a data-memory window back over UART.
`timescale 1ns/1ps
module debug_unit_ctrl #(
  parameter int                NB_REG     = 32,
  parameter int                NB_ADDR    = 5,
  parameter int                NB_WIDHT   = 9,
  parameter int                IMEM_WORDS = 128,
  parameter int                DUMP_WORDS = 32,
  parameter logic [NB_REG-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_start,
  input  logic                i_tx_done,
  output logic                o_dunit_clk_en,
  output logic                o_dunit_reset_pc,
  output logic                o_dunit_w_en,
  output logic [NB_REG-1:0]   o_dunit_mem_addr,
  output logic [NB_REG-1:0]   o_dunit_data_if,
  output logic [NB_ADDR-1:0]  o_dunit_addr,
  input  logic [NB_REG-1:0]   i_dunit_reg,
  output logic [NB_WIDHT-1:0] o_dunit_addr_data,
  input  logic [NB_REG-1:0]   i_dunit_mem_data,
  input  logic                i_halt,
  output logic                o_busy
);

  localparam int NB_PTR = $clog2(IMEM_WORDS) + 1;
  localparam int NB_IDX = (NB_ADDR > $clog2(DUMP_WORDS)) ? NB_ADDR : $clog2(DUMP_WORDS);
  localparam logic [NB_PTR-1:0] PTR_END  = NB_PTR'(IMEM_WORDS);
  localparam logic [NB_IDX-1:0] REG_LAST = NB_IDX'((1 << NB_ADDR) - 1);
  localparam logic [NB_IDX-1:0] MEM_LAST = NB_IDX'(DUMP_WORDS - 1);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;
  localparam logic [7:0] CMD_QUIT = 8'h51;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_BYTE, S_LOAD_WRITE, S_PCRST, S_RUN, S_STEP_WAIT,
    S_STEP_EXEC, S_DUMP_ADDR, S_DUMP_LATCH, S_DUMP_SEND, S_DUMP_WAIT
  } state_t;

  state_t              r_state, w_next_state;
  logic [NB_PTR-1:0]   r_ptr;
  logic [1:0]          r_byte_cnt;
  logic                r_step;
  logic [NB_REG-1:0]   r_asm;
  logic [NB_REG-1:0]   r_word;
  logic [NB_IDX-1:0]   r_dump_idx;
  logic                r_dump_mem;

  logic [NB_PTR-1:0]   w_ptr_inc;
  logic [NB_PTR+1:0]   w_ptr_x4;
  logic [NB_IDX+1:0]   w_idx_x4;
  logic                w_last_reg;
  logic                w_last_item;
  logic [7:0]          w_tx_byte;

  assign w_ptr_inc   = r_ptr + NB_PTR'(1);
  assign w_ptr_x4    = {r_ptr, 2'b00};
  assign w_idx_x4    = {r_dump_idx, 2'b00};
  assign w_last_reg  = !r_dump_mem && (r_dump_idx == REG_LAST);
  assign w_last_item = r_dump_mem && (r_dump_idx == MEM_LAST);
  assign w_tx_byte   = r_word[NB_REG-1 -: 8];

  // Read addresses follow the dump index; the word is shifted left after each byte sent.
  assign o_dunit_addr      = r_dump_idx[NB_ADDR-1:0];
  assign o_dunit_addr_data = NB_WIDHT'(w_idx_x4);
  assign o_busy            = (r_state != S_IDLE) && (r_state != S_STEP_WAIT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_byte_cnt <= '0;
      r_step     <= 1'b0;
      r_asm      <= '0;
      r_word     <= '0;
      r_dump_idx <= '0;
      r_dump_mem <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_LOAD) begin
              r_ptr      <= '0;
              r_byte_cnt <= '0;
            end else if (i_rx_data == CMD_CONT) begin
              r_step <= 1'b0;
            end else if (i_rx_data == CMD_STEP) begin
              r_step <= 1'b1;
            end
          end
        end
        S_LOAD_BYTE: begin
          if (i_rx_valid) begin
            r_asm      <= {r_asm[NB_REG-9:0], i_rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        S_LOAD_WRITE: r_ptr <= w_ptr_inc;
        S_STEP_WAIT: begin
          if (i_rx_valid && (i_rx_data == CMD_QUIT)) r_step <= 1'b0;
        end
        S_RUN, S_STEP_EXEC: begin
          if (w_next_state == S_DUMP_ADDR) begin
            r_dump_idx <= '0;
            r_dump_mem <= 1'b0;
            r_byte_cnt <= '0;
          end
        end
        S_DUMP_LATCH: r_word <= r_dump_mem ? i_dunit_mem_data : i_dunit_reg;
        S_DUMP_WAIT: begin
          if (i_tx_done) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_word     <= r_word << 8;
            if (r_byte_cnt == 2'd3) begin
              if (w_last_item) begin
                if (r_step && i_halt) r_step <= 1'b0;
              end else if (w_last_reg) begin
                r_dump_idx <= '0;
                r_dump_mem <= 1'b1;
              end else begin
                r_dump_idx <= r_dump_idx + NB_IDX'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Address is held for S_DUMP_ADDR and S_DUMP_LATCH so synchronous reads also settle.
  always_comb begin
    w_next_state     = r_state;
    o_tx_data        = '0;
    o_tx_start       = 1'b0;
    o_dunit_clk_en   = 1'b0;
    o_dunit_reset_pc = 1'b0;
    o_dunit_w_en     = 1'b0;
    o_dunit_mem_addr = '0;
    o_dunit_data_if  = '0;
    case (r_state)
      S_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) w_next_state = S_LOAD_BYTE;
          else if ((i_rx_data == CMD_CONT) || (i_rx_data == CMD_STEP)) w_next_state = S_PCRST;
        end
      end
      S_LOAD_BYTE: begin
        if (i_rx_valid && (r_byte_cnt == 2'd3)) w_next_state = S_LOAD_WRITE;
      end
      S_LOAD_WRITE: begin
        o_dunit_w_en     = 1'b1;
        o_dunit_mem_addr = NB_REG'(w_ptr_x4);
        o_dunit_data_if  = r_asm;
        if ((r_asm == HALT_WORD) || (w_ptr_inc == PTR_END)) w_next_state = S_IDLE;
        else w_next_state = S_LOAD_BYTE;
      end
      S_PCRST: begin
        o_dunit_reset_pc = 1'b1;
        w_next_state     = r_step ? S_STEP_WAIT : S_RUN;
      end
      S_RUN: begin
        o_dunit_clk_en = ~i_halt;
        if (i_halt) w_next_state = S_DUMP_ADDR;
      end
      S_STEP_WAIT: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_NEXT) w_next_state = S_STEP_EXEC;
          else if (i_rx_data == CMD_QUIT) w_next_state = S_IDLE;
        end
      end
      S_STEP_EXEC: begin
        o_dunit_clk_en = 1'b1;
        w_next_state   = S_DUMP_ADDR;
      end
      S_DUMP_ADDR:  w_next_state = S_DUMP_LATCH;
      S_DUMP_LATCH: w_next_state = S_DUMP_SEND;
      S_DUMP_SEND: begin
        o_tx_start   = 1'b1;
        o_tx_data    = w_tx_byte;
        w_next_state = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        o_tx_data = w_tx_byte;
        if (i_tx_done) begin
          if (r_byte_cnt != 2'd3) w_next_state = S_DUMP_SEND;
          else if (!w_last_item) w_next_state = S_DUMP_ADDR;
          else if (!r_step || i_halt) w_next_state = S_IDLE;
          else w_next_state = S_STEP_WAIT;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: doc/debug_unit_ctrl.md
Name: debug_unit_ctrl

Overview:
- Host-side sequencer for the MIPS pipeline's debug port.
- Takes command and data bytes from a UART receiver and loads programs into instruction memory through the dunit write port.
- Runs the pipeline continuously or single-step through the dunit clock enable.
- After a run ends or each step completes, dumps the register file and a data-memory window back to the host through a UART transmitter.
- Sits between the UART rx/tx blocks and the pipeline top.

Parameters:
- NB_REG, 32, register/data/instruction width.
- NB_ADDR, 5, register-file address width.
- NB_WIDHT, 9, data-memory byte-address width.
- IMEM_WORDS, 128, instruction-memory capacity in words.
- DUMP_WORDS, 32, data-memory words dumped (byte addresses 0, 4, …, 4*(DUMP_WORDS-1)).
- HALT_WORD, 32'hFFFFFFFF, instruction word that terminates a load.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
- o_tx_data  out  8  byte to transmit
- o_tx_start  out  1  one-cycle pulse, start transmit
- i_tx_done  in  1  one-cycle pulse, byte sent
- o_dunit_clk_en  out  1  pipeline clock enable
- o_dunit_reset_pc  out  1  PC reset pulse
- o_dunit_w_en  out  1  instruction-memory write enable
- o_dunit_mem_addr  out  NB_REG  instruction-memory byte address
- o_dunit_data_if  out  NB_REG  instruction word to write
- o_dunit_addr  out  NB_ADDR  register-file read address
- i_dunit_reg  in  NB_REG  register-file read data
- o_dunit_addr_data  out  NB_WIDHT  data-memory read byte address
- i_dunit_mem_data  in  NB_REG  data-memory read data
- i_halt  in  1  halt instruction reached WB
- o_busy  out  1  high in every state except IDLE and STEP_WAIT

Behaviour:
- Reset: state=IDLE. Every output is 0, including the word pointer, byte counter and step flag. A reset mid-operation aborts immediately, with no partial write and no tx pulse.
- Commands are sampled only in IDLE, and are ignored unless i_rx_valid=1:
  - 'L' (0x4C): clear word pointer, go to LOAD_BYTE.
  - 'C' (0x43): go to PCRST, step flag=0.
  - 'S' (0x53): go to PCRST, step flag=1.
  - Any other byte: ignored, stay in IDLE.
- rx bytes arriving in any state other than IDLE, LOAD_BYTE and STEP_WAIT are discarded.
- LOAD_BYTE:
  - Shift bytes MSB-first into a 32-bit assembly register.
  - After the 4th byte, go to LOAD_WRITE.
- LOAD_WRITE (exactly 1 cycle):
  - o_dunit_w_en=1, o_dunit_mem_addr=4*ptr, o_dunit_data_if=assembled word; then ptr++.
  - If word==HALT_WORD, or ptr reaches IMEM_WORDS after the increment, go to IDLE; otherwise go back to LOAD_BYTE.
  - HALT_WORD itself is written.
  - o_dunit_clk_en=0 throughout the load.
- PCRST (1 cycle): o_dunit_reset_pc=1 with o_dunit_clk_en=0. Next state is RUN if step flag=0, else STEP_WAIT.
- RUN:
  - o_dunit_clk_en = ~i_halt (combinational).
  - On the cycle i_halt=1, the enable is already low and the next state is DUMP_REG.
- STEP_WAIT:
  - clk_en=0.
  - rx 'N' (0x4E): go to STEP_EXEC.
  - rx 'Q' (0x51): go to IDLE.
  - Other bytes ignored.
- STEP_EXEC: exactly one cycle with clk_en=1, then DUMP_REG.
- Dump sequence, registers then memory:
  - For each item, drive its address, wait 1 cycle (DUMP_LATCH), then latch read data. This covers both combinational and 1-cycle synchronous reads.
  - Send the latched word as 4 bytes, MSB first.
  - Per byte: o_tx_start pulses for 1 cycle in DUMP_SEND, with o_tx_data held stable until i_tx_done; DUMP_WAIT waits for i_tx_done before the next byte.
  - Registers 0..31 go out first (128 bytes), then DUMP_WORDS memory words (4*DUMP_WORDS bytes).
  - Total with defaults: 256 bytes.
- End of dump:
  - Continuous mode: go to IDLE.
  - Step mode: if i_halt=1, go to IDLE and clear the step flag; otherwise go to STEP_WAIT.
- o_dunit_clk_en=0 in every state except RUN and STEP_EXEC, so the pipeline is frozen during load and dump.
- An i_tx_done pulse outside DUMP_WAIT is ignored.
- Counters:
  - Word pointer: log2(IMEM_WORDS)+1 bits.
  - Dump index: wraps from 31 to 0 when moving from registers to memory.
  - Memory address = index<<2, truncated to NB_WIDHT.

Test Plan:
- Load: rx 'L', 00 00 00 01, 12 34 56 78, FF FF FF FF → 3 w_en pulses at addr 0/4/8 with data 0x00000001 / 0x12345678 / 0xFFFFFFFF; then IDLE, clk_en never high.
- Continuous run: rx 'C', i_halt raised 20 cycles after RUN entry → 1 reset_pc pulse; clk_en high for exactly 20 cycles; 256 tx bytes; first 4 bytes = reg0 MSB-first (e.g. reg0=0xA1B2C3D4 → A1,B2,C3,D4); byte 129 = mem[0] MSB; then IDLE.
- Step: rx 'S', 'N', 'N' → clk_en high exactly 1 cycle per 'N', a 256-byte dump after each; 'Q' → IDLE, o_busy=0.
- Step to halt: i_halt=1 after the 3rd 'N' → after the dump, state=IDLE; a following 'N' produces no clk_en.
- Load overflow: IMEM_WORDS=4, stream 5 non-halt words → exactly 4 writes (addr 0..12); 5th word bytes ignored in IDLE.
- Reset mid-dump / unknown command: i_reset during byte 50 → all outputs 0 next cycle, no further tx_start; rx 0x7A in IDLE → no state change.
